// File: rtl/hcu_pkg.sv
// Shared definitions for the hazard control unit: instruction field
// constants, flush FSM state encoding and opcode classification helpers.
package hcu_pkg;

    localparam int HCU_WORD_SIZE = 16;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FUNC_JPR = 6'd25;
    localparam logic [5:0] FUNC_JRL = 6'd26;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_t;

    // Register-indirect jumps live in the R-type space.
    function automatic logic func_is_jreg(input logic [5:0] func);
        return (func == FUNC_JPR) || (func == FUNC_JRL);
    endfunction

    // Immediate-only forms (LHI) and absolute jumps do not read rs.
    function automatic logic op_uses_rs(input logic [3:0] op);
        return !((op == OP_LHI) || (op == OP_JMP) || (op == OP_JAL));
    endfunction

    // Two-source branches, stores, and the ALU R-type group read rt.
    function automatic logic op_uses_rt(input logic [3:0] op, input logic [5:0] func);
        return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_SWD) ||
               ((op == OP_RTYPE) && (func <= 6'd3));
    endfunction

    function automatic logic op_is_uncond(input logic [3:0] op, input logic [5:0] func);
        return (op == OP_JMP) || (op == OP_JAL) ||
               ((op == OP_RTYPE) && func_is_jreg(func));
    endfunction

    function automatic logic op_is_jump(input logic [3:0] op, input logic [5:0] func);
        return (op <= OP_BLZ) || op_is_uncond(op, func);
    endfunction

endpackage

// File: rtl/hcu_scoreboard.sv
// Per-register load scoreboard: a down-counter per architectural register
// that is non-zero while a load result for that register is not yet
// forwardable. Everything holds while the pipeline is frozen.
module hcu_scoreboard import hcu_pkg::*; #(
    parameter int NUM_REGS     = 4,
    parameter int REG_ADDR_W   = 2,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,
    input  logic                  load_en,
    input  logic [REG_ADDR_W-1:0] load_dest,
    output logic [NUM_REGS-1:0]   busy
);

    localparam int CNT_W = (LOAD_LATENCY < 1) ? 1 : $clog2(LOAD_LATENCY + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LATENCY);

    logic [CNT_W-1:0] cnt [NUM_REGS];

    // Reload on a new load (overrides any pending count), otherwise count down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load_en && (load_dest == REG_ADDR_W'(i))) begin
                    cnt[i] <= LOAD_VAL;
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // A register is busy while its counter has not drained.
    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller beside the ID stage: load-use stalls via the
// scoreboard, mispredict redirect with a multi-cycle flush, DMA freeze,
// and a saturating stall-cycle counter.
module hazard_control_unit import hcu_pkg::*; #(
    parameter int WORD_SIZE    = HCU_WORD_SIZE,
    parameter int NUM_REGS     = 4,
    parameter int REG_ADDR_W   = 2,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [WORD_SIZE-1:0]  id_inst,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic [WORD_SIZE-1:0]  predicted_next_pc,
    input  logic [WORD_SIZE-1:0]  resolved_pc,
    input  logic [WORD_SIZE-1:0]  fetch_pc,
    input  logic                  dma_bus_busy,
    output logic                  stall,
    output logic                  flush,
    output logic                  pc_redirect,
    output logic [WORD_SIZE-1:0]  redirect_target,
    output logic                  is_jump,
    output logic                  is_uncond,
    output logic [NUM_REGS-1:0]   sb_busy,
    output logic [PERF_W-1:0]     stall_count
);

    localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

    logic [3:0]            opcode;
    logic [5:0]            func;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
    logic                  rs_hazard;
    logic                  rt_hazard;
    logic                  data_stall;
    logic                  freeze;
    logic                  in_flush;
    logic                  mispredict;
    logic                  unused_inst_bits;

    flush_state_t          state;
    logic [FCNT_W-1:0]     flush_cnt;

    assign opcode = id_inst[15:12];
    assign func   = id_inst[5:0];
    assign rs     = id_inst[10 +: REG_ADDR_W];
    assign rt     = id_inst[8 +: REG_ADDR_W];

    // Bits [7:6] carry no information for hazard purposes.
    assign unused_inst_bits = ^id_inst[7:6];

    assign freeze = dma_bus_busy;

    hcu_scoreboard #(
        .NUM_REGS    (NUM_REGS),
        .REG_ADDR_W  (REG_ADDR_W),
        .LOAD_LATENCY(LOAD_LATENCY)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .freeze   (freeze),
        .load_en  (ex_mem_read),
        .load_dest(ex_dest),
        .busy     (sb_busy)
    );

    // Decode, data hazard detection and control-hazard outputs.
    always_comb begin
        use_rs    = op_uses_rs(opcode);
        use_rt    = op_uses_rt(opcode, func);
        is_jump   = id_valid && op_is_jump(opcode, func);
        is_uncond = id_valid && op_is_uncond(opcode, func);

        // A load currently in EX is as much a hazard as one already tracked.
        rs_hazard  = use_rs && ((ex_mem_read && (ex_dest == rs)) || sb_busy[rs]);
        rt_hazard  = use_rt && ((ex_mem_read && (ex_dest == rt)) || sb_busy[rt]);
        data_stall = id_valid && (rs_hazard || rt_hazard);

        in_flush = (state == ST_FLUSH);

        // A resolved PC matching what IF already fetched needs no redirect.
        // During FLUSH the ID stage only holds a bubble.
        mispredict = !reset && is_jump && !freeze && !data_stall && !in_flush &&
                     (resolved_pc != predicted_next_pc) &&
                     (resolved_pc != fetch_pc);

        stall           = !reset && (freeze || data_stall);
        flush           = !reset && (mispredict || (in_flush && !freeze));
        pc_redirect     = mispredict;
        redirect_target = resolved_pc;
    end

    // Flush sequencer: stretches the squash for the remaining redirect cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else if (!freeze) begin
            case (state)
                ST_IDLE: begin
                    if (mispredict && (FLUSH_CYCLES > 1)) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FCNT_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt <= FCNT_W'(1)) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
